// File: rtl/cronometro_memoria_n_if.sv
// Front-panel bundle for the lap stopwatch: switches/keys in, display and status out.
// Module-side ports follow the slave modport; the bench drives through master.
interface cronometro_memoria_n_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic          SW_RUN;
    logic          SW_DISPLAY_MODE;
    logic          KEY_WRITE;
    logic          KEY_READ;
    logic          KEY_CLEAR;
    logic [23:0]   display_bcd;
    logic [AW:0]   lap_count;
    logic [AW-1:0] read_index;
    logic          mem_full;
    logic          mem_empty;
    logic          wr_rejected;
    logic          time_wrapped;

    modport master (
        output SW_RUN, SW_DISPLAY_MODE, KEY_WRITE, KEY_READ, KEY_CLEAR,
        input  display_bcd, lap_count, read_index, mem_full, mem_empty, wr_rejected, time_wrapped
    );

    modport slave (
        input  SW_RUN, SW_DISPLAY_MODE, KEY_WRITE, KEY_READ, KEY_CLEAR,
        output display_bcd, lap_count, read_index, mem_full, mem_empty, wr_rejected, time_wrapped
    );
endinterface

// File: rtl/cronometro_memoria_n.sv
// BCD stopwatch (mm:ss.cc) with a DEPTH-slot lap memory, read back oldest-first.
// Keys are synchronized and edge-detected; lap data comes from a synchronous-read array.
module cronometro_memoria_n #(
    parameter int unsigned CLK_DIV   = 500000,
    parameter int unsigned DEPTH     = 8,
    parameter bit          OVERWRITE = 1'b0
) (
    input logic                   CLOCK_50,
    input logic                   KEY_RESET,
    cronometro_memoria_n_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [23:0] DIGIT_MAX = 24'h595999;

    logic [1:0]    r_rst_sync;
    logic          w_rst_n;
    logic [2:0]    w_key_in;
    logic [2:0]    r_key_s1;
    logic [2:0]    r_key_s2;
    logic [2:0]    r_key_prev;
    logic [1:0]    r_sync_vld;
    logic [2:0]    w_pulse;
    logic          w_wr;
    logic          w_rd;
    logic          w_clr;
    logic [PW-1:0] r_presc;
    logic          w_tick;
    logic [23:0]   r_time;
    logic [23:0]   w_time_next;
    logic          w_carry;
    logic          w_wrap;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_old_ptr;
    logic [AW-1:0] r_rd_idx;
    logic [AW:0]   r_count;
    logic          r_wr_rej;
    logic          r_wrapped;
    logic          w_full;
    logic          w_empty;
    logic          w_store;
    logic          w_rd_last;
    logic [AW-1:0] w_rd_addr;
    logic [23:0]   r_mem [DEPTH];
    logic [23:0]   r_rd_data;

    // Asynchronous assertion, release aligned to CLOCK_50.
    always_ff @(posedge CLOCK_50 or negedge KEY_RESET) begin
        if (!KEY_RESET) r_rst_sync <= '0;
        else            r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_key_in = {bus.KEY_CLEAR, bus.KEY_READ, bus.KEY_WRITE};

    // The edge register only arms once the synchronizer holds real samples, so a key
    // held through reset cannot fake a press on release.
    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_key_s1   <= '1;
            r_key_s2   <= '1;
            r_key_prev <= '0;
            r_sync_vld <= '0;
        end else begin
            r_key_s1   <= w_key_in;
            r_key_s2   <= r_key_s1;
            r_sync_vld <= {r_sync_vld[0], 1'b1};
            r_key_prev <= r_sync_vld[1] ? r_key_s2 : '0;
        end
    end

    assign w_pulse = r_key_prev & ~r_key_s2;
    assign w_wr    = w_pulse[0];
    assign w_rd    = w_pulse[1];
    assign w_clr   = w_pulse[2];

    assign w_tick = bus.SW_RUN && (r_presc == PRESC_MAX);

    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n)        r_presc <= '0;
        else if (bus.SW_RUN) r_presc <= w_tick ? '0 : r_presc + 1'b1;
    end

    // Ripple carry through the six BCD digits, least significant first.
    always_comb begin
        w_time_next = r_time;
        w_carry     = w_tick;
        for (int i = 0; i < 6; i++) begin
            if (w_carry) begin
                if (r_time[4*i +: 4] == DIGIT_MAX[4*i +: 4]) begin
                    w_time_next[4*i +: 4] = 4'd0;
                end else begin
                    w_time_next[4*i +: 4] = r_time[4*i +: 4] + 4'd1;
                    w_carry = 1'b0;
                end
            end
        end
        w_wrap = w_carry;
    end

    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) r_time <= '0;
        else          r_time <= w_time_next;
    end

    assign w_full    = (r_count == (AW + 1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_store   = w_wr && !w_clr && (!w_full || OVERWRITE);
    assign w_rd_last = ({1'b0, r_rd_idx} == (r_count - 1'b1));
    assign w_rd_addr = r_old_ptr + r_rd_idx;

    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_ptr  <= '0;
            r_old_ptr <= '0;
            r_rd_idx  <= '0;
            r_count   <= '0;
            r_wr_rej  <= 1'b0;
            r_wrapped <= 1'b0;
        end else begin
            r_wr_rej <= 1'b0;
            if (w_wrap) r_wrapped <= 1'b1;
            if (w_clr) begin
                r_wr_ptr  <= '0;
                r_old_ptr <= '0;
                r_rd_idx  <= '0;
                r_count   <= '0;
                r_wrapped <= 1'b0;
            end else begin
                if (w_store) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    if (w_full) r_old_ptr <= r_old_ptr + 1'b1;
                    else        r_count   <= r_count + 1'b1;
                end
                if (w_wr && w_full && !OVERWRITE) r_wr_rej <= 1'b1;
                // Wrap is judged against the count before any same-cycle write.
                if (w_rd && !w_empty) r_rd_idx <= w_rd_last ? '0 : r_rd_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (w_store) r_mem[r_wr_ptr] <= r_time;
        r_rd_data <= r_mem[w_rd_addr];
    end

    assign bus.display_bcd  = bus.SW_DISPLAY_MODE ? r_time : (w_empty ? 24'h0 : r_rd_data);
    assign bus.lap_count    = r_count;
    assign bus.read_index   = r_rd_idx;
    assign bus.mem_full     = w_full;
    assign bus.mem_empty    = w_empty;
    assign bus.wr_rejected  = r_wr_rej;
    assign bus.time_wrapped = r_wrapped;
endmodule

// File: tb/tb_cronometro_memoria_n.sv
// Scoreboard bench: two stopwatches (reject / overwrite) share clock, reset and SW_RUN.
// Stimulus queues expected values tagged with a cycle; the monitor compares on that cycle.
module tb_cronometro_memoria_n;
    localparam int K_DISP  = 0;
    localparam int K_LAP   = 1;
    localparam int K_IDX   = 2;
    localparam int K_FULL  = 3;
    localparam int K_EMPTY = 4;
    localparam int K_REJ   = 5;
    localparam int K_WRAP  = 6;

    typedef struct {
        int          cyc;
        int          sel;
        int          kind;
        logic [23:0] val;
        string       name;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t q[$];
    int   cyc;
    int   n_tests;
    int   n_fail;
    int   t;
    int   p;
    int   tw[5];
    int   tx;

    cronometro_memoria_n_if #(.DEPTH(4)) if0 ();
    cronometro_memoria_n_if #(.DEPTH(4)) if1 ();

    cronometro_memoria_n #(.CLK_DIV(4), .DEPTH(4), .OVERWRITE(1'b0)) u_dut0 (
        .CLOCK_50  (clk),
        .KEY_RESET (rst_n),
        .bus       (if0)
    );

    cronometro_memoria_n #(.CLK_DIV(4), .DEPTH(4), .OVERWRITE(1'b1)) u_dut1 (
        .CLOCK_50  (clk),
        .KEY_RESET (rst_n),
        .bus       (if1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [23:0] bcd(input int v);
        int m;
        int s;
        int c;
        m = v / 6000;
        s = (v / 100) % 60;
        c = v % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic logic [23:0] actual(input int sel, input int kind);
        logic [23:0] a;
        a = '0;
        case (kind)
            K_DISP:  a = (sel == 0) ? if0.display_bcd : if1.display_bcd;
            K_LAP:   a = 24'((sel == 0) ? if0.lap_count : if1.lap_count);
            K_IDX:   a = 24'((sel == 0) ? if0.read_index : if1.read_index);
            K_FULL:  a = 24'((sel == 0) ? if0.mem_full : if1.mem_full);
            K_EMPTY: a = 24'((sel == 0) ? if0.mem_empty : if1.mem_empty);
            K_REJ:   a = 24'((sel == 0) ? if0.wr_rejected : if1.wr_rejected);
            default: a = 24'((sel == 0) ? if0.time_wrapped : if1.time_wrapped);
        endcase
        return a;
    endfunction

    task automatic push_exp(input int d, input int sel, input int kind, input logic [23:0] v,
                            input string nm);
        exp_t e;
        e.cyc  = cyc + d;
        e.sel  = sel;
        e.kind = kind;
        e.val  = v;
        e.name = nm;
        q.push_back(e);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc <= cyc) begin
                logic [23:0] a;
                a = actual(q[i].sel, q[i].kind);
                n_tests++;
                if (a !== q[i].val) begin
                    n_fail++;
                    $display("FAIL %s dut%0d: got %h, expected %h", q[i].name, q[i].sel, a,
                             q[i].val);
                end
                q.delete(i);
            end
        end
    end

    task automatic run_cycles(input int n);
        if0.SW_RUN = 1'b1;
        if1.SW_RUN = 1'b1;
        repeat (n) begin
            @(negedge clk);
            p++;
            if (p == 4) begin
                p = 0;
                t = (t + 1) % 360000;
            end
        end
        if0.SW_RUN = 1'b0;
        if1.SW_RUN = 1'b0;
    endtask

    // Mask bits: 0 write, 1 read, 2 clear. Keys go low on the calling negedge.
    task automatic press(input logic [2:0] m0, input logic [2:0] m1);
        if0.KEY_WRITE = ~m0[0];
        if0.KEY_READ  = ~m0[1];
        if0.KEY_CLEAR = ~m0[2];
        if1.KEY_WRITE = ~m1[0];
        if1.KEY_READ  = ~m1[1];
        if1.KEY_CLEAR = ~m1[2];
        repeat (6) @(negedge clk);
        if0.KEY_WRITE = 1'b1;
        if0.KEY_READ  = 1'b1;
        if0.KEY_CLEAR = 1'b1;
        if1.KEY_WRITE = 1'b1;
        if1.KEY_READ  = 1'b1;
        if1.KEY_CLEAR = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        cyc = 0; n_tests = 0; n_fail = 0; t = 0; p = 0; tx = 0;
        rst_n = 1'b1;
        if0.SW_RUN = 1'b0; if0.SW_DISPLAY_MODE = 1'b1;
        if0.KEY_WRITE = 1'b1; if0.KEY_READ = 1'b1; if0.KEY_CLEAR = 1'b1;
        if1.SW_RUN = 1'b0; if1.SW_DISPLAY_MODE = 1'b1;
        if1.KEY_WRITE = 1'b1; if1.KEY_READ = 1'b1; if1.KEY_CLEAR = 1'b1;
        #1 rst_n = 1'b0;

        // Reset state
        @(negedge clk);
        push_exp(1, 0, K_DISP, 24'h0, "reset_display");
        push_exp(1, 0, K_LAP, 24'd0, "reset_lap_count");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        push_exp(1, 0, K_IDX, 24'd0, "reset_read_index");
        push_exp(1, 0, K_EMPTY, 24'd1, "reset_empty");
        push_exp(1, 0, K_FULL, 24'd0, "reset_full");
        push_exp(1, 0, K_WRAP, 24'd0, "reset_wrapped");
        push_exp(1, 1, K_REJ, 24'd0, "reset_rejected");
        @(negedge clk);

        // 400 running cycles = 100 ticks, then hold
        run_cycles(400);
        push_exp(1, 0, K_DISP, 24'h000100, "run_400_cycles");
        repeat (100) @(negedge clk);
        push_exp(1, 0, K_DISP, 24'h000100, "hold_100_cycles");
        push_exp(1, 1, K_DISP, bcd(t), "hold_dut1");
        @(negedge clk);

        // Five laps into both memories at distinct times
        for (int k = 0; k < 5; k++) begin
            run_cycles(8 + 4 * k);
            tw[k] = t;
            if (k == 0) begin
                push_exp(2, 0, K_LAP, 24'd0, "write_not_before_edge3");
                push_exp(3, 0, K_LAP, 24'd1, "write_at_edge3");
            end
            if (k == 4) begin
                push_exp(3, 0, K_REJ, 24'd1, "reject_pulse");
                push_exp(4, 0, K_REJ, 24'd0, "reject_one_cycle");
                push_exp(3, 0, K_LAP, 24'd4, "reject_lap_count");
                push_exp(3, 0, K_FULL, 24'd1, "reject_full");
                push_exp(3, 1, K_LAP, 24'd4, "overwrite_lap_count");
                push_exp(3, 1, K_REJ, 24'd0, "overwrite_no_reject");
            end
            press(3'b001, 3'b001);
        end

        // Lap view: reject keeps first lap, overwrite starts at second
        if0.SW_DISPLAY_MODE = 1'b0;
        if1.SW_DISPLAY_MODE = 1'b0;
        push_exp(1, 0, K_DISP, bcd(tw[0]), "reject_slot0_first_time");
        push_exp(1, 1, K_DISP, bcd(tw[1]), "overwrite_oldest_T2");
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            int nidx;
            nidx = (i + 1) % 4;
            push_exp(3, 1, K_IDX, 24'(nidx), "read_index_step");
            push_exp(4, 1, K_DISP, bcd(tw[1 + nidx]), "read_data_step");
            press(3'b000, 3'b010);
        end

        // Clear while live time is nonzero; lap view of an empty memory is zero
        push_exp(3, 0, K_LAP, 24'd0, "clear_lap_count");
        push_exp(3, 0, K_EMPTY, 24'd1, "clear_empty");
        push_exp(3, 0, K_DISP, 24'h0, "clear_empty_display");
        press(3'b100, 3'b000);

        run_cycles(12);
        tx = t;
        push_exp(3, 0, K_LAP, 24'd1, "single_write");
        push_exp(4, 0, K_DISP, bcd(tx), "single_write_data");
        press(3'b001, 3'b000);

        push_exp(3, 0, K_LAP, 24'd2, "wr_rd_same_cycle_count");
        push_exp(3, 0, K_IDX, 24'd0, "wr_rd_same_cycle_wrap");
        press(3'b011, 3'b000);

        // Preload 59:59.99, one tick wraps
        if0.SW_DISPLAY_MODE = 1'b1;
        if1.SW_DISPLAY_MODE = 1'b1;
        force u_dut0.r_time = 24'h595999;
        force u_dut1.r_time = 24'h595999;
        @(negedge clk);
        release u_dut0.r_time;
        release u_dut1.r_time;
        t = 359999;
        run_cycles(4);
        push_exp(1, 0, K_DISP, 24'h0, "wrap_display");
        push_exp(1, 0, K_WRAP, 24'd1, "wrap_flag");
        push_exp(1, 1, K_WRAP, 24'd1, "wrap_flag_dut1");
        @(negedge clk);
        push_exp(3, 0, K_WRAP, 24'd0, "clear_wrap_flag");
        push_exp(3, 1, K_WRAP, 24'd1, "other_wrap_kept");
        push_exp(3, 0, K_DISP, bcd(t), "clear_keeps_time");
        press(3'b100, 3'b000);

        // Reset while write key is held: no write after release
        if0.KEY_WRITE = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        p = 0;
        repeat (10) @(negedge clk);
        push_exp(1, 0, K_LAP, 24'd0, "held_key_reset_lap");
        push_exp(1, 0, K_EMPTY, 24'd1, "held_key_reset_empty");
        repeat (2) @(negedge clk);
        if0.KEY_WRITE = 1'b1;
        repeat (8) @(negedge clk);
        push_exp(1, 0, K_LAP, 24'd0, "held_key_release_no_write");
        @(negedge clk);
        push_exp(3, 0, K_LAP, 24'd1, "press_after_reset");
        press(3'b001, 3'b000);

        for (int w = 0; w < 20 && q.size() != 0; w++) @(negedge clk);

        n_tests++;
        if (if0.lap_count !== 3'd1) begin
            n_fail++;
            $display("FAIL final_lap_count dut0: got %0d, expected 1", if0.lap_count);
        end
        n_tests++;
        if (if0.mem_empty !== 1'b0) begin
            n_fail++;
            $display("FAIL final_empty dut0: got %b, expected 0", if0.mem_empty);
        end
        n_tests++;
        if (if0.mem_full !== 1'b0) begin
            n_fail++;
            $display("FAIL final_full dut0: got %b, expected 0", if0.mem_full);
        end
        n_tests++;
        if (if0.read_index !== 2'd0) begin
            n_fail++;
            $display("FAIL final_read_index dut0: got %0d, expected 0", if0.read_index);
        end
        n_tests++;
        if (if0.wr_rejected !== 1'b0) begin
            n_fail++;
            $display("FAIL final_rejected dut0: got %b, expected 0", if0.wr_rejected);
        end
        n_tests++;
        if (if0.time_wrapped !== 1'b0) begin
            n_fail++;
            $display("FAIL final_wrapped dut0: got %b, expected 0", if0.time_wrapped);
        end
        n_tests++;
        if (if0.display_bcd !== 24'h0) begin
            n_fail++;
            $display("FAIL final_display dut0: got %h, expected 000000", if0.display_bcd);
        end
        n_tests++;
        if (if1.lap_count !== 3'd0) begin
            n_fail++;
            $display("FAIL final_lap_count dut1: got %0d, expected 0", if1.lap_count);
        end
        n_tests++;
        if (if1.mem_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL final_empty dut1: got %b, expected 1", if1.mem_empty);
        end
        n_tests++;
        if (if1.time_wrapped !== 1'b0) begin
            n_fail++;
            $display("FAIL final_wrapped dut1: got %b, expected 0", if1.time_wrapped);
        end

        while (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s dut%0d: never sampled, expected %h", q[0].name, q[0].sel,
                     q[0].val);
            void'(q.pop_front());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cronometro_memoria_n.md
CRONOMETRO_MEMORIA_N -- requirements
Module: cronometro_memoria_n

Interface
REQ-001 SHALL have parameter CLK_DIV, default 500000, CLOCK_50 cycles per 1/100 s tick (>=2).
REQ-002 SHALL have parameter DEPTH, default 8, number of lap slots (power of 2, 2..64).
REQ-003 SHALL have parameter OVERWRITE, default 0; 1 = circular overwrite of oldest slot when full, 0 = reject writes when full.
REQ-004 SHALL have ports: CLOCK_50  in  1  single system clock, all logic on rising edge.
REQ-005 SHALL have: KEY_RESET  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have: SW_RUN  in  1  level, 1 = count, 0 = hold.
REQ-007 SHALL have: KEY_WRITE, KEY_READ, KEY_CLEAR  in  1 each  active-low push buttons (pre-debounced, asynchronous to CLOCK_50).
REQ-008 SHALL have: SW_DISPLAY_MODE  in  1  1 = live time, 0 = selected lap.
REQ-009 SHALL have: display_bcd  out  24  {min_d, min_u, s_d, s_u, cs_d, cs_u}, BCD.
REQ-010 SHALL have: lap_count  out  clog2(DEPTH)+1  valid slots; read_index  out  clog2(DEPTH)  selected lap, 0 = oldest.
REQ-011 SHALL have: mem_full, mem_empty, wr_rejected, time_wrapped  out  1 each  status flags.

Function
REQ-012 Tick SHALL be a one-cycle enable from a prescaler counting 0..CLK_DIV-1 only while SW_RUN=1; prescaler holds its value while SW_RUN=0; no derived clocks.
REQ-013 On each tick, time SHALL advance as BCD: cs 00..99, s 00..59, min 00..59, carries ripple in the same cycle.
REQ-014 59:59.99 + tick SHALL give 00:00.00 and set sticky time_wrapped.
REQ-015 Each KEY_* SHALL pass a 2-flop synchronizer plus edge detector; one press (high->low) yields exactly one internal pulse; holding the key yields no further pulses.
REQ-016 Action for a press SHALL be visible on outputs at the 3rd rising edge after the low level is first sampled.
REQ-017 Write pulse, not full: store live time at write pointer, increment write pointer (mod DEPTH) and lap_count.
REQ-018 Write pulse, full, OVERWRITE=1: store at write pointer (oldest slot), advance write and oldest pointers, lap_count stays DEPTH.
REQ-019 Write pulse, full, OVERWRITE=0: memory, pointers unchanged; wr_rejected pulses high one cycle.
REQ-020 Read pulse with lap_count>0: read_index increments, wraps to 0 after lap_count-1; with lap_count=0: no change.
REQ-021 Lap storage SHALL be a synchronous-read array; selected lap data SHALL appear on display_bcd one cycle after read_index/oldest pointer change.
REQ-022 Clear pulse SHALL zero lap_count, read_index, both pointers, wr_rejected and time_wrapped; live time unaffected.
REQ-023 Same-cycle priority: clear over write and read; write and read together both take effect, read wrap evaluated against pre-write lap_count.
REQ-024 After an overwrite, read_index SHALL remain relative to the new oldest slot (same index, newer data).
REQ-025 mem_empty = (lap_count==0); mem_full = (lap_count==DEPTH); both combinational from lap_count.
REQ-026 SW_DISPLAY_MODE=0 with mem_empty SHALL show 00:00.00.
REQ-027 Time counters SHALL keep counting across writes, reads, clears.

Reset
REQ-028 KEY_RESET low SHALL asynchronously clear prescaler, time, pointers, lap_count, read_index, flags, synchronizers and edge registers to 0 (synchronizers to the released-key level, 1); display_bcd = 0.
REQ-029 Reset release SHALL be synchronized; first tick no earlier than CLK_DIV cycles after release; lap array contents undefined and not visible (empty).
REQ-030 Reset mid-press SHALL NOT generate a pulse for the held key after release.

Verification (CLK_DIV=4, DEPTH=4)
REQ-031 SW_RUN=1 for 400 cycles from reset -> live display 00:01.00; SW_RUN=0 for 100 cycles -> unchanged.
REQ-032 Preload 59:59.99, one tick -> 00:00.00, time_wrapped=1; clear press -> time_wrapped=0.
REQ-033 OVERWRITE=0: 5 write presses at distinct times -> lap_count=4, mem_full=1, wr_rejected pulse on 5th, slot 0 = first time.
REQ-034 OVERWRITE=1: 5 writes T1..T5, read_index=0 -> display T2 (SW_DISPLAY_MODE=0); 4 read presses -> indices 1,2,3,0.
REQ-035 Write and read pulse same cycle with lap_count=1, read_index=0 -> lap_count=2, read_index=0 (wrapped against count 1).
REQ-036 KEY_RESET asserted while KEY_WRITE held low, released, key still low -> no write, lap_count=0, mem_empty=1.
